// File: rtl/line_engine_pkg.sv
// Shared types and helpers for the queued Bresenham line engine.
package line_engine_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STEP,
        WRITE_1,
        WRITE_2
    } state_t;

    localparam int PIX_PER_BURST = 8;
    localparam int WORD_BYTES    = 16;

    // Byte mask for one 4-pixel word: pixel k owns nibble [15-4k -: 4], 0 = write.
    function automatic logic [WORD_BYTES-1:0] mask_word(input logic [3:0] hit4);
        logic [WORD_BYTES-1:0] m;
        m = '1;
        for (int k = 0; k < 4; k++)
            if (hit4[k]) m[15-4*k -: 4] = 4'h0;
        return m;
    endfunction

endpackage

// File: rtl/line_engine_if.sv
// Command queue and DDR address/write-data FIFO signals of the line engine.
interface line_engine_if
    import line_engine_pkg::*;
#(
    parameter int COORD_W = 10,
    parameter int CNT_W   = 16
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [2*COORD_W-1:0]    cmd_p0;
    logic [2*COORD_W-1:0]    cmd_p1;
    logic [23:0]             cmd_color;
    logic [30:0]             cmd_frame_base;
    logic                    af_full;
    logic                    wdf_full;
    logic [30:0]             af_addr_din;
    logic                    af_wr_en;
    logic [WORD_BYTES*8-1:0] wdf_din;
    logic [WORD_BYTES-1:0]   wdf_mask_din;
    logic                    wdf_wr_en;
    logic                    busy;
    logic [CNT_W-1:0]        lines_done;

    modport master (
        output cmd_valid, cmd_p0, cmd_p1, cmd_color, cmd_frame_base, af_full, wdf_full,
        input  cmd_ready, af_addr_din, af_wr_en, wdf_din, wdf_mask_din, wdf_wr_en, busy, lines_done
    );

    modport slave (
        input  cmd_valid, cmd_p0, cmd_p1, cmd_color, cmd_frame_base, af_full, wdf_full,
        output cmd_ready, af_addr_din, af_wr_en, wdf_din, wdf_mask_din, wdf_wr_en, busy, lines_done
    );
endinterface

// File: rtl/line_engine_mc_cmd_fifo.sv
// Synchronous command FIFO; combinational read of the head entry.
module cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             push, pop;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign push  = wr_en && !full;
    assign pop   = rd_en && !empty;
    assign dout  = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; validity is tracked by count alone.
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= din;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + (AW+1)'(1);
            else if (pop && !push) count <= count - (AW+1)'(1);
        end
    end
endmodule

// File: rtl/line_engine_mc.sv
// Queued Bresenham line rasteriser emitting 2-word masked bursts per 8-pixel block.
module line_engine_mc
    import line_engine_pkg::*;
#(
    parameter int COORD_W   = 10,
    parameter int CMD_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    line_engine_if.slave bus
);
    localparam int SW = COORD_W + 2;
    localparam int CW = 4*COORD_W + 24 + 31;
    typedef logic signed [SW-1:0] sc_t;

    state_t                  state, state_n;
    logic                    fifo_full, fifo_empty, pop;
    logic [CW-1:0]           fifo_dout;
    logic [COORD_W-1:0]      cx0, cy0, cx1, cy1;
    logic [30:0]             base;
    sc_t                     x, y, x_end, dx, dy, err;
    logic                    ystep_neg, steep, line_last;
    logic [PIX_PER_BURST-1:0] hit, hit_now;
    logic [30:0]             addr_q;
    logic [WORD_BYTES-1:0]   mask_q;
    logic [WORD_BYTES*8-1:0] din_q;
    logic [CNT_W-1:0]        done_q;
    logic                    af_en, wdf_en;

    cmd_fifo #(.WIDTH(CW), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (bus.cmd_valid),
        .din   ({bus.cmd_p0, bus.cmd_p1, bus.cmd_color, bus.cmd_frame_base}),
        .full  (fifo_full),
        .rd_en (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty)
    );

    // Setup: normalise so the line runs in +x with |slope| <= 1.
    sc_t sx0, sy0, sx1, sy1, adx, ady, ax0, ay0, ax1, ay1, bx0, by0, bx1, by1;
    logic st, swp;
    assign sx0 = $signed({2'b00, cx0});
    assign sy0 = $signed({2'b00, cy0});
    assign sx1 = $signed({2'b00, cx1});
    assign sy1 = $signed({2'b00, cy1});
    assign adx = (sx1 >= sx0) ? sx1 - sx0 : sx0 - sx1;
    assign ady = (sy1 >= sy0) ? sy1 - sy0 : sy0 - sy1;
    assign st  = ady > adx;
    assign ax0 = st ? sy0 : sx0;
    assign ay0 = st ? sx0 : sy0;
    assign ax1 = st ? sy1 : sx1;
    assign ay1 = st ? sx1 : sy1;
    assign swp = ax0 > ax1;
    assign bx0 = swp ? ax1 : ax0;
    assign by0 = swp ? ay1 : ay0;
    assign bx1 = swp ? ax0 : ax1;
    assign by1 = swp ? ay0 : ay1;

    logic [COORD_W-1:0] col, row, nrow;
    logic [COORD_W-4:0] nblk;
    sc_t                e1, nx, ny, ne;
    logic               last, flush;

    always_comb begin
        col     = steep ? y[COORD_W-1:0] : x[COORD_W-1:0];
        row     = steep ? x[COORD_W-1:0] : y[COORD_W-1:0];
        hit_now = hit | (PIX_PER_BURST'(1) << col[2:0]);
        e1      = err - dy;
        nx      = x + sc_t'(1);
        ny      = y;
        ne      = e1;
        if (e1 < 0) begin
            ny = ystep_neg ? y - sc_t'(1) : y + sc_t'(1);
            ne = e1 + dx;
        end
        nblk  = steep ? ny[COORD_W-1:3] : nx[COORD_W-1:3];
        nrow  = steep ? nx[COORD_W-1:0] : ny[COORD_W-1:0];
        last  = (x == x_end);
        flush = last || ({nrow, nblk} != {row, col[COORD_W-1:3]});
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_n;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        af_en   = 1'b0;
        wdf_en  = 1'b0;
        case (state)
            IDLE:    if (!fifo_empty) begin pop = 1'b1; state_n = SETUP; end
            SETUP:   state_n = STEP;
            STEP:    if (flush) state_n = WRITE_1;
            WRITE_1: begin
                af_en  = 1'b1;
                wdf_en = 1'b1;
                if (!bus.af_full && !bus.wdf_full) state_n = WRITE_2;
            end
            WRITE_2: begin
                wdf_en = 1'b1;
                if (!bus.wdf_full) state_n = line_last ? IDLE : STEP;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {cx0, cy0, cx1, cy1} <= '0;
            base      <= '0;
            {x, y, x_end, dx, dy, err} <= '0;
            ystep_neg <= 1'b0;
            steep     <= 1'b0;
            line_last <= 1'b0;
            hit       <= '0;
            addr_q    <= '0;
            mask_q    <= '1;
            din_q     <= '0;
            done_q    <= '0;
        end else begin
            case (state)
                IDLE: if (!fifo_empty) begin
                    {cx0, cy0, cx1, cy1} <= fifo_dout[CW-1 -: 4*COORD_W];
                    base  <= fifo_dout[30:0];
                    din_q <= {4{8'h00, fifo_dout[54:31]}};
                end
                SETUP: begin
                    x         <= bx0;
                    y         <= by0;
                    x_end     <= bx1;
                    dx        <= bx1 - bx0;
                    dy        <= (by1 >= by0) ? by1 - by0 : by0 - by1;
                    err       <= (bx1 - bx0) >>> 1;
                    ystep_neg <= !(by1 > by0);
                    steep     <= st;
                    hit       <= '0;
                end
                STEP: begin
                    x   <= nx;
                    y   <= ny;
                    err <= ne;
                    hit <= hit_now;
                    if (flush) begin
                        addr_q    <= base + 31'({row, col[COORD_W-1:3], 2'b00});
                        mask_q    <= mask_word(hit_now[3:0]);
                        line_last <= last;
                    end
                end
                WRITE_1: if (!bus.af_full && !bus.wdf_full)
                    mask_q <= mask_word(hit[PIX_PER_BURST-1:4]);
                WRITE_2: if (!bus.wdf_full) begin
                    mask_q <= '1;
                    hit    <= '0;
                    if (line_last) done_q <= done_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready    = !fifo_full;
    assign bus.busy         = !fifo_empty || (state != IDLE);
    assign bus.af_wr_en     = af_en;
    assign bus.wdf_wr_en    = wdf_en;
    assign bus.af_addr_din  = addr_q;
    assign bus.wdf_mask_din = mask_q;
    assign bus.wdf_din      = din_q;
    assign bus.lines_done   = done_q;
endmodule
